// File: rtl/radar_beep_seq_pkg.sv
// Shared types, thresholds, phase lengths and helpers for the radar beep sequencer.
// Latency: none; this file holds only constants and pure functions.
// Backpressure: none.
package radar_beep_pkg;

  typedef enum logic [2:0] {
    BAND_SILENT = 3'd0,
    BAND_SLOW   = 3'd1,
    BAND_MED    = 3'd2,
    BAND_FAST   = 3'd3,
    BAND_CONT   = 3'd4
  } band_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ON,
    ST_OFF,
    ST_CONT
  } state_t;

  // Lower bounds (cm) of the SILENT, SLOW, MED and FAST bands
  localparam logic [8:0] TH_SILENT_CM = 9'd100;
  localparam logic [8:0] TH_SLOW_CM   = 9'd50;
  localparam logic [8:0] TH_MED_CM    = 9'd25;
  localparam logic [8:0] TH_FAST_CM   = 9'd10;

  // Beep cadence, on/off phase lengths in ms
  localparam int MAX_PHASE_MS = 400;
  localparam int MS_W         = $clog2(MAX_PHASE_MS + 1);
  localparam logic [MS_W-1:0] SLOW_ON_MS  = MS_W'(100);
  localparam logic [MS_W-1:0] SLOW_OFF_MS = MS_W'(400);
  localparam logic [MS_W-1:0] MED_ON_MS   = MS_W'(100);
  localparam logic [MS_W-1:0] MED_OFF_MS  = MS_W'(200);
  localparam logic [MS_W-1:0] FAST_ON_MS  = MS_W'(50);
  localparam logic [MS_W-1:0] FAST_OFF_MS = MS_W'(50);

  function automatic band_t classify(input logic [8:0] cm);
    if (cm >= TH_SILENT_CM)    return BAND_SILENT;
    else if (cm >= TH_SLOW_CM) return BAND_SLOW;
    else if (cm >= TH_MED_CM)  return BAND_MED;
    else if (cm >= TH_FAST_CM) return BAND_FAST;
    else                       return BAND_CONT;
  endfunction

  // Only meaningful for the three cadence bands; FAST doubles as the fallback
  function automatic logic [MS_W-1:0] phase_ms(input band_t b, input logic on);
    case (b)
      BAND_SLOW: return on ? SLOW_ON_MS : SLOW_OFF_MS;
      BAND_MED:  return on ? MED_ON_MS  : MED_OFF_MS;
      default:   return on ? FAST_ON_MS : FAST_OFF_MS;
    endcase
  endfunction

  // Closer bands get a higher pitch (smaller half-period)
  function automatic logic [25:0] scaled_div(input logic [25:0] base, input band_t b);
    case (b)
      BAND_SLOW: return base;
      BAND_MED:  return base - (base >> 2);
      default:   return base >> 1;
    endcase
  endfunction

endpackage

// File: rtl/radar_beep_seq_if.sv
// Distance-sample input and tone-generator output bundle of the beep sequencer.
// Latency: none; wires only.
// Backpressure: none; dist_valid is a one-cycle strobe with no ready.
interface radar_beep_seq_if;
  import radar_beep_pkg::*;

  logic        dist_valid;
  logic [8:0]  dist_cm;
  logic        key;
  logic [25:0] div;
  band_t       band;

  modport master (output dist_valid, dist_cm, input key, div, band);
  modport slave  (input dist_valid, dist_cm, output key, div, band);
endinterface

// File: rtl/radar_beep_seq_ms_ticker.sv
// Millisecond prescaler: one-cycle tick every MS_CYCLES clocks, synchronous clear.
// Latency: first tick MS_CYCLES-1 cycles after a clear.
// Backpressure: none.
module ms_ticker #(
  parameter int MS_CYCLES = 27000
) (
  input  logic clk,
  input  logic nrst,
  input  logic clr,
  output logic tick
);
  localparam int W = (MS_CYCLES > 1) ? $clog2(MS_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(MS_CYCLES - 1);

  logic [W-1:0] cnt;

  assign tick = (cnt == LAST);

  // Free-running modulo-MS_CYCLES counter, restarted by clr
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/radar_beep_seq.sv
// Distance-to-cadence buzzer sequencer; RADAR_PITCH_SCALE_EN selects band-dependent pitch.
// Latency: band 1 edge after the dist_valid sample, key/div 1 edge after band.
// Backpressure: none; every dist_valid is accepted, back-to-back strobes allowed.
module radar_beep_seq
  import radar_beep_pkg::*;
#(
  parameter int MS_CYCLES  = 27000,
  parameter int TIMEOUT_MS = 500,
  parameter int DIV_BASE   = 6749
) (
  input logic            clk,
  input logic            nrst,
  radar_beep_seq_if.slave bus
);
  localparam int TMAX = TIMEOUT_MS * MS_CYCLES;
  localparam int TO_W = $clog2(TMAX);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TMAX - 1);
  localparam logic [25:0] DIV_BASE_V = 26'(DIV_BASE);
  localparam logic [MS_W-1:0] MS_ONE = MS_W'(1);

  band_t             band_q;
  state_t            state;
  logic              key_q;
  logic [25:0]       div_q;
  logic [25:0]       div_sel;
  logic [TO_W-1:0]   to_cnt;
  logic [MS_W-1:0]   ms_cnt;
  logic [MS_W-1:0]   len;
  logic              tick;
  logic              cadence;
  logic              in_phase;
  logic              phase_end;
  logic              phase_enter;
  logic              enter_on;

`ifdef RADAR_PITCH_SCALE_EN
  assign div_sel = scaled_div(DIV_BASE_V, band_q);
`else
  assign div_sel = DIV_BASE_V;
`endif

  assign cadence     = (band_q == BAND_SLOW) || (band_q == BAND_MED) || (band_q == BAND_FAST);
  assign in_phase    = (state == ST_ON) || (state == ST_OFF);
  assign phase_end   = in_phase && tick && (ms_cnt == len - MS_ONE);
  // A cadence phase starts from IDLE/CONT immediately, or from ON/OFF at phase end
  assign phase_enter = cadence && (!in_phase || phase_end);
  assign enter_on    = (state == ST_IDLE) || (state == ST_OFF);

  ms_ticker #(.MS_CYCLES(MS_CYCLES)) u_ms_ticker (
    .clk  (clk),
    .nrst (nrst),
    .clr  (phase_enter),
    .tick (tick)
  );

  // Band register and receive timeout; a fresh sample beats the timeout
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      band_q <= BAND_SILENT;
      to_cnt <= '0;
    end else if (bus.dist_valid) begin
      band_q <= classify(bus.dist_cm);
      to_cnt <= '0;
    end else if (to_cnt == TO_LAST) begin
      band_q <= BAND_SILENT;
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // Phase ms counter; length is frozen at entry so mid-phase band changes wait
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ms_cnt <= '0;
      len    <= '0;
    end else if (phase_enter) begin
      ms_cnt <= '0;
      len    <= phase_ms(band_q, enter_on);
    end else if (in_phase && tick && !phase_end) begin
      ms_cnt <= ms_cnt + MS_ONE;
    end
  end

  // Cadence FSM with registered key/div; div only moves when a tone starts
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= ST_IDLE;
      key_q <= 1'b0;
      div_q <= DIV_BASE_V;
    end else begin
      case (state)
        ST_IDLE: begin
          if (band_q == BAND_CONT) begin
            state <= ST_CONT;
            key_q <= 1'b1;
            div_q <= div_sel;
          end else if (cadence) begin
            state <= ST_ON;
            key_q <= 1'b1;
            div_q <= div_sel;
          end
        end
        ST_ON, ST_OFF: begin
          if (band_q == BAND_SILENT) begin
            state <= ST_IDLE;
            key_q <= 1'b0;
          end else if (band_q == BAND_CONT) begin
            state <= ST_CONT;
            key_q <= 1'b1;
            div_q <= div_sel;
          end else if (phase_end) begin
            if (state == ST_ON) begin
              state <= ST_OFF;
              key_q <= 1'b0;
            end else begin
              state <= ST_ON;
              key_q <= 1'b1;
              div_q <= div_sel;
            end
          end
        end
        default: begin
          if (band_q == BAND_SILENT) begin
            state <= ST_IDLE;
            key_q <= 1'b0;
          end else if (cadence) begin
            state <= ST_OFF;
            key_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.key  = key_q;
  assign bus.div  = div_q;
  assign bus.band = band_q;
endmodule

// File: tb/tb_radar_beep_seq.sv
// Bench for radar_beep_seq: scoreboard of output-change events against a cycle-level model.
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_radar_beep_seq;
  import radar_beep_pkg::*;

  localparam int MS     = 4;
  localparam int TO_MS  = 1000;
  localparam int TMAX   = TO_MS * MS;
  localparam int TO2_MS = 20;
  localparam int DIVB   = 6749;
`ifdef RADAR_PITCH_SCALE_EN
  localparam int EXP_SLOW = 6749, EXP_MED = 5062, EXP_FAST = 3374;
`else
  localparam int EXP_SLOW = 6749, EXP_MED = 6749, EXP_FAST = 6749;
`endif

  // Model modes: silent, beep tone on, beep gap, steady tone
  localparam int M_QUIET = 0, M_ON = 1, M_OFF = 2, M_STEADY = 3;

  typedef struct { int t; int key; int div; int band; } ev_t;

  logic clk = 1'b0;
  logic nrst;
  int   cyc;
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;
  ev_t  q[$];

  int m_band, m_mode, m_left, m_last, m_key, m_div, t;

  always #5 clk = ~clk;

  radar_beep_seq_if bus();
  radar_beep_seq_if bus2();

  radar_beep_seq #(.MS_CYCLES(MS), .TIMEOUT_MS(TO_MS), .DIV_BASE(DIVB)) dut (
    .clk(clk), .nrst(nrst), .bus(bus.slave));

  radar_beep_seq #(.MS_CYCLES(MS), .TIMEOUT_MS(TO2_MS), .DIV_BASE(DIVB)) dut2 (
    .clk(clk), .nrst(nrst), .bus(bus2.slave));

  always @(posedge clk or negedge nrst) begin
    if (!nrst) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  function automatic int band_of(input int cm);
    if (cm >= 100) return 0;
    if (cm >= 50)  return 1;
    if (cm >= 25)  return 2;
    if (cm >= 10)  return 3;
    return 4;
  endfunction

  function automatic int on_cyc(input int b);
    return (b == 3) ? 50 * MS : 100 * MS;
  endfunction

  function automatic int off_cyc(input int b);
    return (b == 1) ? 400 * MS : (b == 2) ? 200 * MS : 50 * MS;
  endfunction

  function automatic int tone(input int b);
`ifdef RADAR_PITCH_SCALE_EN
    if (b == 1) return DIVB;
    if (b == 2) return DIVB - DIVB / 4;
    return DIVB / 2;
`else
    return (b >= 0) ? DIVB : DIVB;
`endif
  endfunction

  task automatic model_reset();
    t = 0; m_last = 0; m_band = 0; m_mode = M_QUIET; m_left = 0; m_key = 0; m_div = DIVB;
  endtask

  // One clock edge of the behavioural model; the tone follows the band seen before the edge
  task automatic model_edge(input bit dv, input int cm);
    int b, pk, pd, pb;
    ev_t e;
    b = m_band; pk = m_key; pd = m_div; pb = m_band;
    t++;
    case (m_mode)
      M_QUIET: begin
        if (b == 4) begin m_mode = M_STEADY; m_div = tone(b); end
        else if (b != 0) begin m_mode = M_ON; m_left = on_cyc(b); m_div = tone(b); end
      end
      M_ON, M_OFF: begin
        if (b == 0) m_mode = M_QUIET;
        else if (b == 4) begin m_mode = M_STEADY; m_div = tone(b); end
        else begin
          m_left--;
          if (m_left == 0) begin
            if (m_mode == M_ON) begin m_mode = M_OFF; m_left = off_cyc(b); end
            else begin m_mode = M_ON; m_left = on_cyc(b); m_div = tone(b); end
          end
        end
      end
      default: begin
        if (b == 0) m_mode = M_QUIET;
        else if (b != 4) begin m_mode = M_OFF; m_left = off_cyc(b); end
      end
    endcase
    m_key = (m_mode == M_ON || m_mode == M_STEADY) ? 1 : 0;
    if (dv) begin m_band = band_of(cm); m_last = t; end
    else if (t - m_last == TMAX) m_band = 0;
    if (m_key != pk || m_div != pd || m_band != pb) begin
      e.t = t; e.key = m_key; e.div = m_div; e.band = m_band;
      q.push_back(e);
    end
  endtask

  task automatic step(input bit dv, input int cm);
    bus.dist_valid = dv;
    bus.dist_cm = 9'(cm);
    @(posedge clk);
    model_edge(dv, cm);
    #1;
    bus.dist_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 0);
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic strobe2(input int cm);
    bus2.dist_valid = 1'b1;
    bus2.dist_cm = 9'(cm);
    step(1'b0, 0);
    bus2.dist_valid = 1'b0;
  endtask

  // Monitor: every change of key/div/band must match the next predicted event
  initial begin
    int pk, pd, pb;
    ev_t e;
    pk = 0; pd = 0; pb = 0;
    forever begin
      @(negedge clk);
      if (mon_en && (int'(bus.key) != pk || int'(bus.div) != pd || int'(bus.band) != pb)) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected: cyc=%0d got key=%0d div=%0d band=%0d, expected no change",
                   cyc, bus.key, bus.div, bus.band);
        end else begin
          e = q.pop_front();
          if (e.t != cyc || e.key != int'(bus.key) || e.div != int'(bus.div) || e.band != int'(bus.band)) begin
            failures++;
            $display("FAIL sb_event: got cyc=%0d key=%0d div=%0d band=%0d, expected cyc=%0d key=%0d div=%0d band=%0d",
                     cyc, bus.key, bus.div, bus.band, e.t, e.key, e.div, e.band);
          end
        end
      end
      pk = int'(bus.key); pd = int'(bus.div); pb = int'(bus.band);
    end
  end

  task automatic do_reset(input string tag);
    mon_en = 1'b0;
    nrst = 1'b0;
    #1;
    chk({tag, "_key"},  int'(bus.key),  0);
    chk({tag, "_band"}, int'(bus.band), 0);
    chk({tag, "_div"},  int'(bus.div),  DIVB);
    q.delete();
    model_reset();
    @(negedge clk);
    @(posedge clk);
    #1;
    nrst = 1'b1;
    mon_en = 1'b1;
  endtask

  initial begin
    int b, cm, gap;
    bus.dist_valid = 1'b0;  bus.dist_cm = '0;
    bus2.dist_valid = 1'b0; bus2.dist_cm = '0;
    nrst = 1'b1;
    #2;
    do_reset("rst0");

    // Slow cadence with periodic refresh
    step(1'b1, 60);
    repeat (9) begin idle(499); step(1'b1, 60); end
    idle(20);

    // Reset asserted in the middle of a beep, then checked after release
    chk("pre_rst_key", int'(bus.key), m_key);
    do_reset("rst_mid");
    step(1'b0, 0);
    chk("post_rst_key",  int'(bus.key),  0);
    chk("post_rst_band", int'(bus.band), 0);
    chk("post_rst_div",  int'(bus.div),  DIVB);

    // Continuous tone, then a far target silences it
    step(1'b1, 5);
    idle(30);
    chk("cont_key", int'(bus.key), 1);
    step(1'b1, 150);
    chk("silence_key_hold", int'(bus.key), 1);
    step(1'b0, 0);
    chk("silence_key", int'(bus.key), 0);
    idle(5);

    // Band change mid-ON only affects the following phases
    step(1'b1, 60);
    idle(51);
    step(1'b1, 15);
    idle(1000);

    // Pitch at ON entry for each cadence band
    step(1'b1, 200); idle(3); step(1'b1, 60); step(1'b0, 0);
    chk("slow_key", int'(bus.key), 1); chk("slow_div", int'(bus.div), EXP_SLOW);
    step(1'b1, 200); idle(3); step(1'b1, 30); step(1'b0, 0);
    chk("med_key", int'(bus.key), 1);  chk("med_div", int'(bus.div), EXP_MED);
    step(1'b1, 200); idle(3); step(1'b1, 12); step(1'b0, 0);
    chk("fast_key", int'(bus.key), 1); chk("fast_div", int'(bus.div), EXP_FAST);
    step(1'b1, 200); idle(3);

    // Receive timeout on the short-timeout instance
    strobe2(30);
    idle(79);
    chk("to_band_before", int'(bus2.band), 2);
    step(1'b0, 0);
    chk("to_band", int'(bus2.band), 0);
    chk("to_key_hold", int'(bus2.key), 1);
    step(1'b0, 0);
    chk("to_key", int'(bus2.key), 0);
    // A strobe in the terminal cycle prevents the timeout
    strobe2(30);
    idle(79);
    strobe2(30);
    chk("to_race_band", int'(bus2.band), 2);
    step(1'b0, 0);
    chk("to_race_band_next", int'(bus2.band), 2);
    chk("to_race_key", int'(bus2.key), 1);

    // Receive timeout on the main instance
    step(1'b1, 40);
    idle(TMAX + 20);

    // Randomized distances and gaps, including back-to-back strobes
    for (int i = 0; i < 40; i++) begin
      b = $urandom_range(0, 4);
      case (b)
        0: cm = $urandom_range(100, 511);
        1: cm = $urandom_range(50, 99);
        2: cm = $urandom_range(25, 49);
        3: cm = $urandom_range(10, 24);
        default: cm = $urandom_range(0, 9);
      endcase
      gap = ($urandom_range(0, 3) == 0) ? 1 : $urandom_range(2, 900);
      step(1'b1, cm);
      idle(gap - 1);
    end

    idle(5);
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/radar_beep_seq.md
# radar_beep_seq

Distance-to-cadence sequencer for the radar buzzer path. It consumes distance samples from the ranging front end, classifies each into a proximity band, and drives the `key` and `div` inputs of the downstream tone generator. Far targets are silent. Closer targets beep with progressively faster on/off cadence, and the nearest band gives a continuous tone. A receive timeout silences the buzzer when measurements stop arriving.

## Interface
- `MS_CYCLES`, default 27000: clk cycles per 1 ms (27 MHz board clock).
- `TIMEOUT_MS`, default 500: ms without `dist_valid` before the band is forced to SILENT.
- `DIV_BASE`, default 6749: base tone divider (about 2 kHz at 27 MHz).
- `clk`, in, 1: single system clock, rising edge.
- `nrst`, in, 1: asynchronous, active-low reset.
- `dist_valid`, in, 1: one-cycle strobe; `dist_cm` is valid in this cycle.
- `dist_cm`, in, 9: distance in cm, 0..511.
- `key`, out, 1: tone enable to the tone generator; 1 means sound.
- `div`, out, 26: tone half-period divider to the tone generator.
- `band`, out, 3: current band. 0 SILENT, 1 SLOW, 2 MED, 3 FAST, 4 CONT.

## Operation
- **Banding.** Each `dist_valid` classifies `dist_cm` into `band` on the next edge:
  - ≥100 gives SILENT.
  - 50..99 gives SLOW.
  - 25..49 gives MED.
  - 10..24 gives FAST.
  - <10 gives CONT.
- **Phase lengths (ms, on/off).** SLOW 100/400, MED 100/200, FAST 50/50.
- **Timeout.** A cycle counter is cleared by `dist_valid` and otherwise counts up. When it reaches `TIMEOUT_MS*MS_CYCLES-1`, `band` becomes SILENT. If `dist_valid` arrives in the same cycle, `dist_valid` wins and the counter clears.
- **FSM states.** IDLE (key=0), ON (key=1), OFF (key=0), CONT (key=1).
  - IDLE: band CONT goes to CONT. A cadence band goes to ON.
  - ON: SILENT goes to IDLE and CONT goes to CONT, both immediately. Otherwise, at phase end go to OFF.
  - OFF: SILENT goes to IDLE and CONT goes to CONT, both immediately. Otherwise, at phase end go to ON.
  - CONT: SILENT goes to IDLE. A cadence band goes to OFF of the new band.
- **Phase timing.**
  - Phase length is latched from `band` at phase entry. A cadence-band change mid-phase takes effect at the next phase.
  - On every phase entry, the ms prescaler and the phase ms counter clear. Every phase therefore lasts exactly len*`MS_CYCLES` cycles.
- **Registers.** `key` and `div` are registered. `div` updates only on entry to ON or CONT, so pitch is constant within a beep.
- **Arithmetic.** Phase counters are sized by `$clog2` of the maximum product. Timeout counter width is `$clog2(TIMEOUT_MS*MS_CYCLES)`. No wrap is possible because counters clear at terminal count.

## Timing
- **Reset values.** `key`=0, `div`=`DIV_BASE`, `band`=0, state IDLE, all counters 0.
- **Asynchronous reset mid-beep.** `key` drops immediately, with no phase completion.
- **Latency.** With `dist_valid` at edge N, `band` updates at N+1. FSM state and `key`/`div` update at N+2.
- **Timeout latency.** `band` goes to 0 one edge after terminal count, and `key` goes to 0 one edge later.
- **Handshake.** No backpressure. Back-to-back `dist_valid` strobes are legal, and the last one before a phase boundary sets the next phase.

## Configuration
- `RADAR_PITCH_SCALE_EN` defined: `div` is chosen by band.
  - SLOW: `DIV_BASE`.
  - MED: `DIV_BASE - (DIV_BASE>>2)`.
  - FAST and CONT: `DIV_BASE>>1`.
- `RADAR_PITCH_SCALE_EN` undefined: `div` is constant `DIV_BASE` for all bands.

## Structure
- **Package `radar_beep_pkg`.**
  - `band_t` enum, 3-bit.
  - `state_t` enum.
  - Band threshold constants: 100, 50, 25, 10.
  - Per-band on/off ms constants.
- **Sub-module `ms_ticker`.** Prescaler with synchronous clear, emitting a 1-cycle tick every `MS_CYCLES` cycles. Instantiated once, cleared on phase entry.

## Test plan
Bench uses `MS_CYCLES`=4 and `TIMEOUT_MS`=1000 unless noted.
1. Reset asserted mid-run → `key`=0, `band`=0, `div`=6749 immediately and after release.
2. `dist_valid`, `dist_cm`=60 at edge N, then refresh every 500 cycles → `key`=1 from N+2 for 400 cycles, 0 for 1600 cycles, and repeating.
3. `dist_cm`=5 → `key` held 1 continuously. Then `dist_cm`=150 → `key`=0 two edges later and state IDLE.
4. SLOW ON, then `dist_cm`=15 at ON cycle 50 → ON still ends at cycle 400, followed by OFF of 200 cycles and ON of 200 cycles.
5. `TIMEOUT_MS`=20, single `dist_cm`=30 then silence → `band`=0 after 80 cycles and `key`=0 one edge later. `dist_valid` on the terminal cycle → no timeout.
6. With `RADAR_PITCH_SCALE_EN`: SLOW, MED and FAST give `div`=6749, 5062 and 3374 at ON entry. Without the macro, 6749 in all three cases.
